// File: rtl/bc_datapath.sv
// Basic-computer datapath: AR/PC/DR/AC/IR/TR/E registers, 8-source common bus,
// ALU into AC, and a word memory with async read at AR plus a boot write port.
module bc_datapath #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned CTRL_LNGTH = 21
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              BUS_SEL,
  input  logic [3*CTRL_LNGTH-1:0] CTRL,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [WIDTH-1:0]        ld_data,
  output logic [WIDTH-1:0]        IR,
  output logic [WIDTH-1:0]        AC,
  output logic                    E,
  output logic [WIDTH-1:0]        BUS,
  output logic                    AC_ZERO,
  output logic                    DR_ZERO
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam int unsigned S_AR_LD  = 0;
  localparam int unsigned S_AR_INR = 1;
  localparam int unsigned S_AR_CLR = 2;
  localparam int unsigned S_PC_LD  = 3;
  localparam int unsigned S_PC_INR = 4;
  localparam int unsigned S_PC_CLR = 5;
  localparam int unsigned S_DR_LD  = 6;
  localparam int unsigned S_DR_INR = 7;
  localparam int unsigned S_DR_CLR = 8;
  localparam int unsigned S_AC_LD  = 9;
  localparam int unsigned S_AC_INR = 10;
  localparam int unsigned S_AC_CLR = 11;
  localparam int unsigned S_IR_LD  = 12;
  localparam int unsigned S_TR_LD  = 13;
  localparam int unsigned S_TR_INR = 14;
  localparam int unsigned S_TR_CLR = 15;
  localparam int unsigned S_MEM_WR = 16;
  localparam int unsigned S_E_CMP  = 17;
  localparam int unsigned S_E_CLR  = 19;
  localparam int unsigned S_ALU_OP = 20;

  logic [ADDR_W-1:0] r_ar;
  logic [ADDR_W-1:0] r_pc;
  logic [WIDTH-1:0]  r_dr;
  logic [WIDTH-1:0]  r_ac;
  logic [WIDTH-1:0]  r_ir;
  logic [WIDTH-1:0]  r_tr;
  logic              r_e;
  logic [WIDTH-1:0]  r_mem [DEPTH];

  logic [WIDTH-1:0]  w_bus;
  logic [WIDTH-1:0]  w_alu_res;
  logic              w_alu_e;
  logic              w_alu_e_upd;
  logic [2:0]        w_alu_op;
  logic              w_unused;

  // Only bit 0 of each single-bit slot is decoded; the rest is deliberately ignored.
  assign w_alu_op = CTRL[3*S_ALU_OP +: 3];
  assign w_unused = ^CTRL;

  // Common bus source mux
  always_comb begin
    w_bus = '0;
    case (BUS_SEL)
      3'b000:  w_bus = '0;
      3'b001:  w_bus = WIDTH'(r_pc);
      3'b010:  w_bus = WIDTH'(r_ar);
      3'b011:  w_bus = r_dr;
      3'b100:  w_bus = r_ir;
      3'b101:  w_bus = r_ac;
      3'b110:  w_bus = r_mem[r_ar];
      default: w_bus = r_tr;
    endcase
  end

  // ALU result and E side effect for AC_LD
  always_comb begin
    w_alu_res   = r_ac;
    w_alu_e     = r_e;
    w_alu_e_upd = 1'b0;
    case (w_alu_op)
      3'b000: w_alu_res = r_ac & r_dr;
      3'b001: begin
        {w_alu_e, w_alu_res} = {1'b0, r_ac} + {1'b0, r_dr};
        w_alu_e_upd          = 1'b1;
      end
      3'b010: w_alu_res = r_dr;
      3'b011: w_alu_res = ~r_ac;
      3'b100: begin
        w_alu_res   = {r_e, r_ac[WIDTH-1:1]};
        w_alu_e     = r_ac[0];
        w_alu_e_upd = 1'b1;
      end
      3'b101: begin
        w_alu_res   = {r_ac[WIDTH-2:0], r_e};
        w_alu_e     = r_ac[WIDTH-1];
        w_alu_e_upd = 1'b1;
      end
      3'b110:  w_alu_res = r_ac;
      default: w_alu_res = w_bus;
    endcase
  end

  // Register file: per register CLR > LD > INR, reset overrides everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar <= '0;
      r_pc <= '0;
      r_dr <= '0;
      r_ac <= '0;
      r_ir <= '0;
      r_tr <= '0;
      r_e  <= 1'b0;
    end else begin
      if (CTRL[3*S_AR_CLR])      r_ar <= '0;
      else if (CTRL[3*S_AR_LD])  r_ar <= w_bus[ADDR_W-1:0];
      else if (CTRL[3*S_AR_INR]) r_ar <= r_ar + ADDR_W'(1);

      if (CTRL[3*S_PC_CLR])      r_pc <= '0;
      else if (CTRL[3*S_PC_LD])  r_pc <= w_bus[ADDR_W-1:0];
      else if (CTRL[3*S_PC_INR]) r_pc <= r_pc + ADDR_W'(1);

      if (CTRL[3*S_DR_CLR])      r_dr <= '0;
      else if (CTRL[3*S_DR_LD])  r_dr <= w_bus;
      else if (CTRL[3*S_DR_INR]) r_dr <= r_dr + WIDTH'(1);

      if (CTRL[3*S_AC_CLR])      r_ac <= '0;
      else if (CTRL[3*S_AC_LD])  r_ac <= w_alu_res;
      else if (CTRL[3*S_AC_INR]) r_ac <= r_ac + WIDTH'(1);

      if (CTRL[3*S_IR_LD])       r_ir <= w_bus;

      if (CTRL[3*S_TR_CLR])      r_tr <= '0;
      else if (CTRL[3*S_TR_LD])  r_tr <= w_bus;
      else if (CTRL[3*S_TR_INR]) r_tr <= r_tr + WIDTH'(1);

      // ALU carry/shift-out only lands when AC_LD actually wins over AC_CLR
      if (CTRL[3*S_E_CLR])      r_e <= 1'b0;
      else if (CTRL[3*S_E_CMP]) r_e <= ~r_e;
      else if (CTRL[3*S_AC_LD] && !CTRL[3*S_AC_CLR] && w_alu_e_upd) r_e <= w_alu_e;
    end
  end

  // Memory writes: boot port is issued last so it wins on an address collision
  always_ff @(posedge clk) begin
    if (!rst && CTRL[3*S_MEM_WR]) r_mem[r_ar] <= w_bus;
    if (ld_en)                    r_mem[ld_addr] <= ld_data;
  end

  assign IR      = r_ir;
  assign AC      = r_ac;
  assign E       = r_e;
  assign BUS     = w_bus;
  assign AC_ZERO = (r_ac == '0);
  assign DR_ZERO = (r_dr == '0);

endmodule

// File: tb/tb_bc_datapath.sv
// Directed bench for bc_datapath: fetch, ALU ops, E handling, priorities,
// wrap-around, store, memory write arbitration and reset behaviour.
module tb_bc_datapath;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned WIDTH  = 16;
  localparam int unsigned CL     = 21;

  localparam int AR_LD = 0,  AR_INR = 1,  PC_LD = 3,  PC_INR = 4, PC_CLR = 5;
  localparam int DR_LD = 6,  DR_INR = 7,  AC_LD = 9,  AC_INR = 10, IR_LD = 12;
  localparam int TR_LD = 13, TR_INR = 14, MEM_WR = 16, E_CMP = 17, E_CLR = 19;

  logic              clk;
  logic              rst;
  logic [2:0]        BUS_SEL;
  logic [3*CL-1:0]   CTRL;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [WIDTH-1:0]  ld_data;
  logic [WIDTH-1:0]  IR;
  logic [WIDTH-1:0]  AC;
  logic              E;
  logic [WIDTH-1:0]  BUS;
  logic              AC_ZERO;
  logic              DR_ZERO;

  int tests_run;
  int tests_failed;

  bc_datapath #(.ADDR_W(ADDR_W), .WIDTH(WIDTH), .CTRL_LNGTH(CL)) dut (
    .clk(clk), .rst(rst), .BUS_SEL(BUS_SEL), .CTRL(CTRL),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .IR(IR), .AC(AC), .E(E), .BUS(BUS), .AC_ZERO(AC_ZERO), .DR_ZERO(DR_ZERO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3*CL-1:0] s(input int k);
    return (3*CL)'(1) << (3*k);
  endfunction

  function automatic logic [3*CL-1:0] op(input logic [2:0] o);
    return (3*CL)'(o) << 60;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given bus source and control word; inputs settle after the edge
  task automatic cyc(input logic [2:0] sel, input logic [3*CL-1:0] ctl);
    BUS_SEL = sel;
    CTRL    = ctl;
    @(posedge clk);
    #1;
    CTRL  = '0;
    ld_en = 1'b0;
  endtask

  task automatic ldm(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    cyc(3'b000, '0);
  endtask

  task automatic peek(input logic [2:0] sel);
    BUS_SEL = sel;
    #1;
  endtask

  logic [3*CL-1:0] rsv;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1; BUS_SEL = '0; CTRL = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;

    // reset, with a boot write issued while reset is held
    @(negedge clk);
    ldm(12'h000, 16'h7800);
    cyc(3'b000, '0);
    chk("rst_ac", AC, 16'h0000);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_e", {15'b0, E}, 16'h0000);
    chk("rst_aczero", {15'b0, AC_ZERO}, 16'h0001);
    chk("rst_drzero", {15'b0, DR_ZERO}, 16'h0001);
    peek(3'b001); chk("rst_pc", BUS, 16'h0000);
    peek(3'b111); chk("rst_tr", BUS, 16'h0000);
    rst = 1'b0;

    // fetch
    cyc(3'b001, s(AR_LD));
    peek(3'b110); chk("boot_mem", BUS, 16'h7800);
    cyc(3'b110, s(IR_LD) | s(PC_INR));
    chk("fetch_ir", IR, 16'h7800);
    peek(3'b001); chk("fetch_pc", BUS, 16'h0001);

    // ADD with carry
    cyc(3'b000, s(AC_LD) | op(3'b011));
    chk("cma_ffff", AC, 16'hFFFF);
    cyc(3'b000, s(DR_INR));
    chk("dr_nz", {15'b0, DR_ZERO}, 16'h0000);
    peek(3'b011); chk("dr_one", BUS, 16'h0001);
    cyc(3'b000, s(AC_LD) | op(3'b001));
    chk("add_ac", AC, 16'h0000);
    chk("add_e", {15'b0, E}, 16'h0001);
    chk("add_aczero", {15'b0, AC_ZERO}, 16'h0001);

    // complement and rotates
    ldm(12'h000, 16'h00F0);
    cyc(3'b110, s(AC_LD) | op(3'b111));
    chk("ld_bus", AC, 16'h00F0);
    cyc(3'b000, s(AC_LD) | op(3'b011));
    chk("cma", AC, 16'hFF0F);
    cyc(3'b000, s(E_CLR));
    chk("e_clr", {15'b0, E}, 16'h0000);
    cyc(3'b000, s(AC_LD) | op(3'b100));
    chk("shr_ac", AC, 16'h7F87);
    chk("shr_e", {15'b0, E}, 16'h0001);
    cyc(3'b000, s(AC_LD) | op(3'b101));
    chk("shl_ac", AC, 16'hFF0F);
    chk("shl_e", {15'b0, E}, 16'h0000);
    cyc(3'b000, s(AC_LD) | op(3'b000));
    chk("and", AC, 16'h0001);

    // E priority
    cyc(3'b000, s(E_CMP));
    chk("e_cmp", {15'b0, E}, 16'h0001);
    cyc(3'b000, s(E_CLR) | s(E_CMP));
    chk("e_clr_pri", {15'b0, E}, 16'h0000);
    cyc(3'b000, s(E_CMP) | s(AC_LD) | op(3'b001));
    chk("cmp_over_alu_ac", AC, 16'h0002);
    chk("cmp_over_alu_e", {15'b0, E}, 16'h0001);

    // PC load truncation, wrap and priority
    ldm(12'h000, 16'hFFFF);
    cyc(3'b110, s(PC_LD));
    peek(3'b001); chk("pc_ld_trunc", BUS, 16'h0FFF);
    cyc(3'b000, s(PC_INR));
    peek(3'b001); chk("pc_wrap", BUS, 16'h0000);
    ldm(12'h000, 16'h0123);
    cyc(3'b110, s(PC_LD) | s(PC_INR));
    peek(3'b001); chk("pc_ld_over_inr", BUS, 16'h0123);
    cyc(3'b001, s(PC_CLR) | s(PC_LD) | s(PC_INR));
    peek(3'b001); chk("pc_clr_pri", BUS, 16'h0000);

    // store, including write address sampled before AR increments
    ldm(12'h010, 16'h0000);
    ldm(12'h000, 16'h1234);
    cyc(3'b110, s(DR_LD));
    ldm(12'h000, 16'hBEEF);
    cyc(3'b110, s(AC_LD) | op(3'b111));
    ldm(12'h000, 16'h000F);
    cyc(3'b110, s(AR_LD));
    cyc(3'b101, s(MEM_WR) | s(AR_INR));
    peek(3'b010); chk("ar_inr", BUS, 16'h0010);
    peek(3'b110); chk("wr_old_ar", BUS, 16'h0000);
    cyc(3'b101, s(MEM_WR));
    peek(3'b110); chk("store", BUS, 16'hBEEF);

    // boot port wins an address collision
    ld_en = 1'b1; ld_addr = 12'h010; ld_data = 16'h1111;
    cyc(3'b101, s(MEM_WR));
    peek(3'b110); chk("ld_pri", BUS, 16'h1111);
    cyc(3'b101, s(MEM_WR));
    peek(3'b110); chk("restore", BUS, 16'hBEEF);

    // reset mid-operation
    cyc(3'b000, s(AC_LD) | op(3'b010));
    chk("ac_from_dr", AC, 16'h1234);
    cyc(3'b101, s(TR_LD));
    peek(3'b111); chk("tr_ld", BUS, 16'h1234);
    rst = 1'b1;
    cyc(3'b101, s(AC_LD) | op(3'b111) | s(E_CMP) | s(PC_INR) | s(AR_INR) |
                s(DR_INR) | s(TR_INR) | s(MEM_WR) | s(IR_LD));
    rst = 1'b0;
    chk("mrst_ac", AC, 16'h0000);
    chk("mrst_e", {15'b0, E}, 16'h0000);
    chk("mrst_ir", IR, 16'h0000);
    chk("mrst_aczero", {15'b0, AC_ZERO}, 16'h0001);
    chk("mrst_drzero", {15'b0, DR_ZERO}, 16'h0001);
    peek(3'b001); chk("mrst_pc", BUS, 16'h0000);
    peek(3'b010); chk("mrst_ar", BUS, 16'h0000);
    peek(3'b111); chk("mrst_tr", BUS, 16'h0000);
    ldm(12'h000, 16'h0010);
    cyc(3'b110, s(AR_LD));
    peek(3'b110); chk("mem_kept", BUS, 16'hBEEF);

    // reserved slot and upper slot bits do nothing
    rsv = '0;
    for (int k = 0; k < 20; k++) rsv |= (3*CL)'(3'b110) << (3*k);
    rsv |= (3*CL)'(3'b111) << 54;
    cyc(3'b110, rsv);
    chk("rsv_ac", AC, 16'h0000);
    chk("rsv_ir", IR, 16'h0000);
    chk("rsv_drzero", {15'b0, DR_ZERO}, 16'h0001);
    peek(3'b010); chk("rsv_ar", BUS, 16'h0010);
    peek(3'b001); chk("rsv_pc", BUS, 16'h0000);

    // DR/TR/AC wrap, AC_INR leaves E alone
    cyc(3'b000, s(AC_LD) | op(3'b011));
    cyc(3'b101, s(DR_LD) | s(TR_LD) | s(E_CMP));
    chk("dr_ffff", {15'b0, DR_ZERO}, 16'h0000);
    cyc(3'b000, s(DR_INR) | s(AC_INR) | s(TR_INR));
    chk("dr_wrap", {15'b0, DR_ZERO}, 16'h0001);
    chk("ac_wrap", AC, 16'h0000);
    chk("ac_inr_e", {15'b0, E}, 16'h0001);
    peek(3'b111); chk("tr_wrap", BUS, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
